// File: rtl/mac_pkg.sv
// mac_pkg: shared precision encodings, widths and drain FSM states for the MAC result path
package mac_pkg;
    localparam int ACC_W = 56;
    localparam int ACT_W = 8;
    localparam logic [1:0] PREC_FULL = 2'b00;
    localparam logic [1:0] PREC_W4   = 2'b01;
    localparam logic [1:0] PREC_W2   = 2'b10;
    localparam logic [1:0] PREC_RSVD = 2'b11;
    typedef enum logic {IDLE, EMIT} state_e;
    function automatic logic [2:0] lanes_of(input logic [1:0] prec);
        return prec == PREC_W2 ? 3'd4 : prec == PREC_W4 ? 3'd2 : 3'd1;
    endfunction
endpackage

// File: rtl/requant_lane.sv
// requant_lane: round-half-up, arithmetic right shift and saturation of one signed accumulator lane
module requant_lane #(
    parameter int LANE_W  = 14,
    parameter int ACT_W   = 8,
    parameter int SHIFT_W = 6
) (
    input  logic [LANE_W-1:0]  lane_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [ACT_W-1:0]   act_o,
    output logic               clip_o
);
    localparam logic signed [LANE_W:0] MAXV = (LANE_W+1)'(2**(ACT_W-1) - 1);
    localparam logic signed [LANE_W:0] MINV = ~MAXV;
    localparam logic [LANE_W:0] ONE = 1;
    logic [SHIFT_W-1:0] s;
    logic signed [LANE_W:0] rnd, shd;
    logic hi, lo;
    // one extra bit keeps the rounding bias from overflowing the lane
    always_comb begin
        s = (32'(shift_i) > LANE_W - 1) ? SHIFT_W'(LANE_W - 1) : shift_i;
        rnd = $signed({lane_i[LANE_W-1], lane_i}) + $signed((ONE << s) >> 1);
        shd = rnd >>> s;
        hi = shd > MAXV;
        lo = shd < MINV;
        clip_o = hi || lo;
        act_o = hi ? ACT_W'(MAXV) : lo ? ACT_W'(MINV) : shd[ACT_W-1:0];
    end
endmodule

// File: rtl/mac_result_drain.sv
// mac_result_drain: accepts packed accumulator words, requantizes 1/2/4 lanes and streams them one per beat
module mac_result_drain #(
    parameter int ACC_W    = 56,
    parameter int ACT_W    = 8,
    parameter int SHIFT_W  = 6,
    parameter int SATCNT_W = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic [1:0]          prec_level,
    input  logic [SHIFT_W-1:0]  shift,
    input  logic                acc_valid,
    output logic                acc_ready,
    input  logic [ACC_W-1:0]    acc_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACT_W-1:0]    out_act,
    output logic                out_last,
    output logic                err_rsvd,
    output logic [SATCNT_W-1:0] sat_count,
    input  logic                sat_clr
);
    import mac_pkg::*;
    localparam int L2 = ACC_W / 2;
    localparam int L4 = ACC_W / 4;
    state_e state_q;
    logic [ACC_W-1:0] acc_q;
    logic [1:0] prec_q, k_q;
    logic [SHIFT_W-1:0] shift_q;
    logic out_valid_q, out_last_q, clip_q, err_q;
    logic [ACT_W-1:0] act_q;
    logic [SATCNT_W-1:0] sat_q;
    logic capture, beat;
    logic [ACC_W-1:0] src_acc;
    logic [1:0] src_prec, src_idx;
    logic [SHIFT_W-1:0] src_shift;
    logic [1:0][L2-1:0] w4;
    logic [3:0][L4-1:0] w2;
    logic [ACT_W-1:0] a1, a2, a4, act_d;
    logic c1, c2, c4, clip_d;

    assign acc_ready = en && state_q == IDLE;
    assign capture   = acc_valid && acc_ready;
    assign beat      = out_valid_q && out_ready && en;
    // lane 0 comes straight from the input word at capture, later lanes from the latched word
    assign src_acc   = capture ? acc_result : acc_q;
    assign src_prec  = capture ? prec_level : prec_q;
    assign src_shift = capture ? shift : shift_q;
    assign src_idx   = capture ? 2'd0 : k_q + 2'd1;
    assign w4 = src_acc;
    assign w2 = src_acc;

    requant_lane #(.LANE_W(ACC_W), .ACT_W(ACT_W), .SHIFT_W(SHIFT_W)) u_full (
        .lane_i(src_acc), .shift_i(src_shift), .act_o(a1), .clip_o(c1));
    requant_lane #(.LANE_W(L2), .ACT_W(ACT_W), .SHIFT_W(SHIFT_W)) u_w4 (
        .lane_i(w4[src_idx[0]]), .shift_i(src_shift), .act_o(a2), .clip_o(c2));
    requant_lane #(.LANE_W(L4), .ACT_W(ACT_W), .SHIFT_W(SHIFT_W)) u_w2 (
        .lane_i(w2[src_idx]), .shift_i(src_shift), .act_o(a4), .clip_o(c4));

    assign act_d  = src_prec == PREC_FULL ? a1 : src_prec == PREC_W4 ? a2 : a4;
    assign clip_d = src_prec == PREC_FULL ? c1 : src_prec == PREC_W4 ? c2 : c4;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            prec_q      <= '0;
            shift_q     <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            act_q       <= '0;
            clip_q      <= 1'b0;
            err_q       <= 1'b0;
            sat_q       <= '0;
        end else if (en) begin
            err_q <= !sat_clr && (err_q || (capture && prec_level == PREC_RSVD));
            if (sat_clr) sat_q <= '0;
            else if (beat && clip_q && !(&sat_q)) sat_q <= sat_q + 1'b1;
            if (capture && prec_level != PREC_RSVD) begin
                state_q     <= EMIT;
                acc_q       <= acc_result;
                prec_q      <= prec_level;
                shift_q     <= shift;
                k_q         <= '0;
                out_valid_q <= 1'b1;
                act_q       <= act_d;
                clip_q      <= clip_d;
                out_last_q  <= lanes_of(prec_level) == 3'd1;
            end else if (beat && out_last_q) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else if (beat) begin
                k_q        <= src_idx;
                act_q      <= act_d;
                clip_q     <= clip_d;
                out_last_q <= {1'b0, src_idx} + 3'd1 == lanes_of(prec_q);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_act   = act_q;
    assign out_last  = out_last_q;
    assign err_rsvd  = err_q;
    assign sat_count = sat_q;
endmodule

// File: tb/tb_mac_result_drain.sv
// tb_mac_result_drain: directed table, corner sequences and randomized words against an arithmetic lane model
module tb_mac_result_drain;
    logic clk = 0, rstn, en, acc_valid, out_ready, sat_clr;
    logic [1:0] prec_level;
    logic [5:0] shift;
    logic [55:0] acc_result;
    logic acc_ready, out_valid, out_last, err_rsvd;
    logic [7:0] out_act;
    logic [15:0] sat_count;
    int n_cmp = 0, n_fail = 0, sat_exp = 0;

    always #5 clk = ~clk;

    mac_result_drain dut (
        .clk(clk), .rstn(rstn), .en(en), .prec_level(prec_level), .shift(shift),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_result(acc_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act), .out_last(out_last),
        .err_rsvd(err_rsvd), .sat_count(sat_count), .sat_clr(sat_clr));

    typedef struct {
        logic [1:0] p;
        logic [5:0] sh;
        logic [55:0] a;
        int n;
        logic [3:0][7:0] ex;
        int clips;
        int mode;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // lane value = signed slice, scaled by 2^-s with round half up, clamped to int8
    function automatic void model(input logic [1:0] p, input logic [5:0] sh, input logic [55:0] a,
                                  output int n, output logic [3:0][7:0] ex, output int clips);
        longint lane, v, one;
        int L, s;
        one = 1;
        n = (p == 2'd0) ? 1 : (p == 2'd1) ? 2 : 4;
        L = 56 / n;
        ex = '0;
        clips = 0;
        for (int i = 0; i < n; i++) begin
            lane = longint'((a >> (i * L)) & ((56'd1 << L) - 56'd1));
            if (lane >= (one << (L - 1))) lane = lane - (one << L);
            s = (int'(sh) < L - 1) ? int'(sh) : L - 1;
            v = (lane + ((s > 0) ? (one << (s - 1)) : 0)) >>> s;
            if (v > 127) begin v = 127; clips++; end
            else if (v < -128) begin v = -128; clips++; end
            ex[i] = v[7:0];
        end
    endfunction

    // mode 0: always ready; 1: random ready/en; 2: ready low 5 cycles and en low 2 cycles mid-word
    task automatic run_word(input string nm, input logic [1:0] p, input logic [5:0] sh, input logic [55:0] a,
                            input int n, input logic [3:0][7:0] ex, input int clips, input int mode);
        int k = 0, cyc = 0;
        logic held = 0, pl = 0;
        logic [7:0] pa = 0;
        en = 1;
        out_ready = 0;
        check({nm, " rdy"}, acc_ready, 1);
        acc_valid = 1; prec_level = p; shift = sh; acc_result = a;
        @(posedge clk); #1;
        acc_valid = 0;
        prec_level = 2'($urandom);
        shift = 6'($urandom);
        acc_result = 56'({$urandom(), $urandom()});
        check({nm, " lat"}, out_valid, 1);
        while (k < n && cyc < 200) begin
            if (held) begin
                check({nm, " hold_act"}, out_act, pa);
                check({nm, " hold_last"}, out_last, pl);
            end
            check({nm, " vld"}, out_valid, 1);
            check({nm, " busy"}, acc_ready, 0);
            out_ready = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 ? !(cyc >= 2 && cyc <= 6) : 1'b1;
            en = mode == 1 ? ($urandom_range(0, 3) != 0) : mode == 2 ? !(cyc == 3 || cyc == 4) : 1'b1;
            if (out_ready && en) begin
                check($sformatf("%s act%0d", nm, k), out_act, ex[k]);
                check($sformatf("%s last%0d", nm, k), out_last, k == n - 1);
                k++;
                held = 0;
            end else begin
                held = 1;
                pa = out_act;
                pl = out_last;
            end
            @(posedge clk); #1;
            cyc++;
        end
        en = 1;
        out_ready = 0;
        check({nm, " beats"}, k, n);
        check({nm, " drained"}, out_valid, 0);
        sat_exp += clips;
        check({nm, " sat"}, sat_count, sat_exp);
    endtask

    vec_t tbl[6];
    logic [55:0] t3;
    logic [3:0][7:0] ex;
    int n, clips;
    logic [1:0] p;
    logic [5:0] sh;
    logic [55:0] a;

    initial begin
        t3 = {14'h2000, 14'h3FFF, 14'd7, 14'd300};
        tbl[0] = '{2'd0, 6'd3, 56'd1000, 1, {8'h00, 8'h00, 8'h00, 8'd125}, 0, 0};
        tbl[1] = '{2'd1, 6'd1, {28'd255, 28'hFFFFFFB}, 2, {8'h00, 8'h00, 8'h7F, 8'hFE}, 1, 0};
        tbl[2] = '{2'd2, 6'd2, t3, 4, {8'h80, 8'h00, 8'h02, 8'd75}, 1, 0};
        tbl[3] = '{2'd2, 6'd2, t3, 4, {8'h80, 8'h00, 8'h02, 8'd75}, 1, 2};
        tbl[4] = '{2'd0, 6'd0, 56'hFFFFFFFFFFFF9C, 1, {8'h00, 8'h00, 8'h00, 8'h9C}, 0, 1};
        tbl[5] = '{2'd2, 6'd63, {14'd4095, 14'd0, 14'h2000, 14'h1FFF}, 4, {8'h00, 8'h00, 8'hFF, 8'h01}, 0, 1};

        rstn = 0; en = 1; acc_valid = 0; out_ready = 0; sat_clr = 0;
        prec_level = 0; shift = 0; acc_result = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst out_act", out_act, 0);
        check("rst out_last", out_last, 0);
        check("rst err_rsvd", err_rsvd, 0);
        check("rst sat_count", sat_count, 0);
        check("rst acc_ready", acc_ready, 1);
        en = 0; #1;
        check("rst acc_ready_en0", acc_ready, 0);
        en = 1;
        rstn = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_word($sformatf("v%0d", i), tbl[i].p, tbl[i].sh, tbl[i].a, tbl[i].n, tbl[i].ex, tbl[i].clips, tbl[i].mode);

        acc_valid = 1; prec_level = 2'b11; shift = 0; acc_result = 56'd77;
        @(posedge clk); #1;
        acc_valid = 0;
        check("rsvd acc_ready", acc_ready, 1);
        check("rsvd out_valid", out_valid, 0);
        check("rsvd err", err_rsvd, 1);
        repeat (3) @(posedge clk);
        #1;
        check("rsvd out_valid_later", out_valid, 0);
        check("rsvd err_sticky", err_rsvd, 1);
        sat_clr = 1;
        @(posedge clk); #1;
        sat_clr = 0;
        check("clr err", err_rsvd, 0);
        check("clr sat", sat_count, 0);
        sat_exp = 0;

        out_ready = 1;
        acc_valid = 1; prec_level = 2'd2; shift = 6'd2; acc_result = t3;
        @(posedge clk); #1;
        acc_valid = 0;
        @(posedge clk); #1;
        check("t6 lane1", out_act, 8'h02);
        out_ready = 0;
        rstn = 0; #1;
        check("t6 out_valid", out_valid, 0);
        check("t6 out_act", out_act, 0);
        check("t6 out_last", out_last, 0);
        check("t6 sat", sat_count, 0);
        check("t6 acc_ready", acc_ready, 1);
        @(posedge clk); #1;
        check("t6 held_in_rst", out_valid, 0);
        rstn = 1;
        sat_exp = 0;
        @(posedge clk); #1;
        check("t6 no_partial", out_valid, 0);
        run_word("t6 redo", 2'd2, 6'd2, t3, 4, {8'h80, 8'h00, 8'h02, 8'd75}, 1, 0);

        for (int i = 0; i < 40; i++) begin
            p = 2'($urandom_range(0, 2));
            sh = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'($urandom_range(0, 14));
            a = 56'({$urandom(), $urandom()});
            model(p, sh, a, n, ex, clips);
            run_word($sformatf("r%0d", i), p, sh, a, n, ex, clips, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
